// File: rtl/icache_fetch_arbiter.sv
// Round-robin arbiter that puts the fetches of two icaches onto one RAM read port.
// It hands the RAM to the data/coherence side whenever that side asks between fetches.
module icache_fetch_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        iren,
    input  logic [ADDR_W-1:0] iaddr0,
    input  logic [ADDR_W-1:0] iaddr1,
    output logic [1:0]        iwait,
    output logic [DATA_W-1:0] iload0,
    output logic [DATA_W-1:0] iload1,
    input  logic              dbus_req,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ibus_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              owner_req;
    logic [ADDR_W-1:0] owner_addr;
    logic              fetch_abort;
    logic              fetch_done;
    logic              grant_valid;
    logic              grant_core;

    // The owner withdrawing or moving its address cancels the fetch, even if RAM answers now.
    assign owner_req   = owner_q ? iren[1] : iren[0];
    assign owner_addr  = owner_q ? iaddr1 : iaddr0;
    assign fetch_abort = !owner_req || (owner_addr != addr_q);
    assign fetch_done  = !fetch_abort && (ramstate == RAM_ACCESS);

    assign grant_valid = !dbus_req && (iren != 2'b00);
    assign grant_core  = (iren == 2'b11) ? ~last_grant_q : iren[1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = FETCH;
                    owner_d = grant_core;
                    addr_d  = grant_core ? iaddr1 : iaddr0;
                end
            end
            FETCH: begin
                if (fetch_abort) begin
                    state_d = IDLE;
                end else if (fetch_done) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait     = 2'b11;
        iload0    = '0;
        iload1    = '0;
        ram_ren   = 1'b0;
        ram_addr  = '0;
        ibus_busy = 1'b0;
        if (state_q == FETCH) begin
            ram_ren   = 1'b1;
            ram_addr  = addr_q;
            ibus_busy = 1'b1;
            if (fetch_done) begin
                if (owner_q) begin
                    iwait[1] = 1'b0;
                    iload1   = ramload;
                end else begin
                    iwait[0] = 1'b0;
                    iload0   = ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// Self-checking bench for icache_fetch_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level reference model.
module tb_icache_fetch_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [1:0]        iren;
    logic [ADDR_W-1:0] iaddr0, iaddr1;
    logic [1:0]        iwait;
    logic [DATA_W-1:0] iload0, iload1;
    logic              dbus_req;
    logic              ram_ren;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ibus_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one outstanding fetch (who, which address) plus who was served last.
    bit              m_fetching;
    bit              m_owner;
    bit              m_last;
    logic [ADDR_W-1:0] m_addr;

    icache_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .nRST(nRST), .iren(iren), .iaddr0(iaddr0), .iaddr1(iaddr1),
        .iwait(iwait), .iload0(iload0), .iload1(iload1), .dbus_req(dbus_req),
        .ram_ren(ram_ren), .ram_addr(ram_addr), .ramload(ramload),
        .ramstate(ramstate), .ibus_busy(ibus_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [ADDR_W-1:0] req_addr(input bit core);
        return core ? iaddr1 : iaddr0;
    endfunction

    // A fetch still stands if its owner keeps asking for the same address.
    function automatic bit fetch_stands();
        return m_fetching && iren[m_owner] && (req_addr(m_owner) == m_addr);
    endfunction

    task automatic applyStimulus(input logic [1:0] ren, input logic [ADDR_W-1:0] a0,
                                 input logic [ADDR_W-1:0] a1, input logic dreq,
                                 input logic [1:0] rs, input logic [DATA_W-1:0] rl);
        iren = ren; iaddr0 = a0; iaddr1 = a1;
        dbus_req = dreq; ramstate = rs; ramload = rl;
        #1;
    endtask

    task automatic checkOutput();
        logic [1:0]        e_iwait;
        logic [DATA_W-1:0] e_l0, e_l1;
        e_iwait = 2'b11; e_l0 = '0; e_l1 = '0;
        if (fetch_stands() && ramstate == RS_ACCESS) begin
            e_iwait[m_owner] = 1'b0;
            if (m_owner) e_l1 = ramload; else e_l0 = ramload;
        end
        check("iwait", 64'(iwait), 64'(e_iwait));
        check("iload0", 64'(iload0), 64'(e_l0));
        check("iload1", 64'(iload1), 64'(e_l1));
        check("ram_ren", 64'(ram_ren), 64'(m_fetching));
        check("ram_addr", 64'(ram_addr), m_fetching ? 64'(m_addr) : 64'd0);
        check("ibus_busy", 64'(ibus_busy), 64'(m_fetching));
    endtask

    task automatic step_model();
        bit winner;
        if (!m_fetching) begin
            if (!dbus_req && iren != 2'b00) begin
                winner     = (iren == 2'b11) ? !m_last : iren[1];
                m_owner    = winner;
                m_addr     = req_addr(winner);
                m_fetching = 1'b1;
            end
        end else if (!fetch_stands()) begin
            m_fetching = 1'b0;
        end else if (ramstate == RS_ACCESS) begin
            m_last     = m_owner;
            m_fetching = 1'b0;
        end
    endtask

    task automatic endCycle();
        checkOutput();
        step_model();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic model_reset();
        m_fetching = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_addr = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iwait"}, 64'(iwait), 64'h3);
        check({tag, "_iload0"}, 64'(iload0), 64'h0);
        check({tag, "_iload1"}, 64'(iload1), 64'h0);
        check({tag, "_ren"}, 64'(ram_ren), 64'h0);
        check({tag, "_addr"}, 64'(ram_addr), 64'h0);
        check({tag, "_busy"}, 64'(ibus_busy), 64'h0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        applyStimulus(2'b00, '0, '0, 1'b0, RS_FREE, '0);
        model_reset();
        check_reset_outputs("reset");
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        int served [$];
        logic [ADDR_W-1:0] served_addr [$];
        int busy_cnt;
        int pulses;
        logic [ADDR_W-1:0] ra0, ra1;

        nRST = 1'b0;
        iren = '0; iaddr0 = '0; iaddr1 = '0; dbus_req = 1'b0; ramstate = RS_FREE; ramload = '0;
        model_reset();
        @(negedge CLK);
        do_reset();

        $display("[TB] single fetch core 0");
        applyStimulus(2'b01, 32'h100, 32'h0, 1'b0, RS_FREE, '0);
        check("t1_idle_ren", 64'(ram_ren), 64'h0);
        endCycle();
        applyStimulus(2'b01, 32'h100, 32'h0, 1'b0, RS_ACCESS, 32'hDEADBEEF);
        check("t1_addr", 64'(ram_addr), 64'h100);
        check("t1_ren", 64'(ram_ren), 64'h1);
        check("t1_iwait", 64'(iwait), 64'h2);
        check("t1_iload0", 64'(iload0), 64'hDEADBEEF);
        endCycle();
        applyStimulus(2'b00, 32'h100, 32'h0, 1'b0, RS_FREE, '0);
        check("t1_back_idle", 64'(ram_ren), 64'h0);
        endCycle();

        $display("[TB] alternating grants");
        do_reset();
        busy_cnt = 0;
        pulses = 0;
        for (int c = 0; c < 40 && served.size() < 3; c++) begin
            logic [1:0] rs;
            rs = RS_FREE;
            if (m_fetching) begin
                rs = (busy_cnt < 2) ? RS_BUSY : RS_ACCESS;
                busy_cnt = (busy_cnt < 2) ? busy_cnt + 1 : 0;
            end
            applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, rs, 32'(c));
            if (iwait != 2'b11) begin
                pulses++;
                served.push_back(iwait[0] ? 1 : 0);
                served_addr.push_back(ram_addr);
            end
            endCycle();
        end
        check("t2_serves", 64'(served.size()), 64'd3);
        check("t2_pulses", 64'(pulses), 64'd3);
        if (served.size() == 3) begin
            check("t2_order0", 64'(served[0]), 64'd0);
            check("t2_order1", 64'(served[1]), 64'd1);
            check("t2_order2", 64'(served[2]), 64'd0);
            check("t2_addr0", 64'(served_addr[0]), 64'h10);
            check("t2_addr1", 64'(served_addr[1]), 64'h20);
            check("t2_addr2", 64'(served_addr[2]), 64'h10);
        end
        applyStimulus(2'b00, 32'h10, 32'h20, 1'b0, RS_FREE, '0);
        endCycle();

        $display("[TB] yield to data side");
        do_reset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b01, 32'h40, 32'h0, 1'b1, RS_FREE, '0);
            check("t3_ren_held", 64'(ram_ren), 64'h0);
            check("t3_busy_held", 64'(ibus_busy), 64'h0);
            endCycle();
        end
        applyStimulus(2'b01, 32'h40, 32'h0, 1'b0, RS_FREE, '0);
        check("t3_drop_ren", 64'(ram_ren), 64'h0);
        endCycle();
        applyStimulus(2'b01, 32'h40, 32'h0, 1'b1, RS_ACCESS, 32'h55);
        check("t3_granted", 64'(ram_ren), 64'h1);
        check("t3_no_preempt", 64'(iwait), 64'h2);
        endCycle();

        $display("[TB] abort keeps last grant");
        applyStimulus(2'b10, 32'h10, 32'h20, 1'b0, RS_FREE, '0);
        endCycle();
        applyStimulus(2'b10, 32'h10, 32'h20, 1'b0, RS_BUSY, '0);
        check("t4_addr", 64'(ram_addr), 64'h20);
        endCycle();
        applyStimulus(2'b00, 32'h10, 32'h20, 1'b0, RS_BUSY, '0);
        check("t4_abort_iwait", 64'(iwait), 64'h3);
        endCycle();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, RS_FREE, '0);
        check("t4_idle", 64'(ram_ren), 64'h0);
        endCycle();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, RS_ACCESS, 32'h1234);
        check("t4_regrant_addr", 64'(ram_addr), 64'h20);
        check("t4_iwait", 64'(iwait), 64'h1);
        check("t4_iload1", 64'(iload1), 64'h1234);
        endCycle();

        $display("[TB] error retry");
        pulses = 0;
        applyStimulus(2'b01, 32'h300, 32'h20, 1'b0, RS_FREE, '0);
        endCycle();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b01, 32'h300, 32'h20, 1'b0, (c < 3) ? RS_ERROR : RS_ACCESS, 32'hCAFE);
            check("t5_ren", 64'(ram_ren), 64'h1);
            check("t5_addr", 64'(ram_addr), 64'h300);
            if (iwait != 2'b11) pulses++;
            endCycle();
        end
        check("t5_pulses", 64'(pulses), 64'd1);

        $display("[TB] reset during fetch");
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, RS_FREE, '0);
        endCycle();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, RS_BUSY, '0);
        check("t6_fetching", 64'(ram_ren), 64'h1);
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("t6_async");
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, RS_FREE, '0);
        endCycle();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0, RS_ACCESS, 32'h77);
        check("t6_core0_first", 64'(ram_addr), 64'h10);
        endCycle();

        $display("[TB] random traffic");
        ra0 = 32'h40; ra1 = 32'h80;
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] ren;
            if ($urandom_range(0, 9) == 0) ra0 = 32'($urandom_range(0, 3)) << 2;
            if ($urandom_range(0, 9) == 0) ra1 = 32'h80 + (32'($urandom_range(0, 3)) << 2);
            ren = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 1) == 0) ren = 2'($urandom);
            applyStimulus(ren, ra0, ra1, ($urandom_range(0, 3) == 0), 2'($urandom), $urandom);
            endCycle();
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_fetch_arbiter.md
Name: icache_fetch_arbiter

Overview:
- Instruction-side front end of the memory system for the dual-core design.
- Arbitrates fetch requests from the two icaches onto one RAM read port with round-robin fairness, and returns the fetched word and wait signal to the winning core.
- Sits between the icaches and the coherence bus controller / RAM.
- Yields the RAM to the data/coherence side whenever that side asserts dbus_req between fetches.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction word width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iren  in  2  fetch request; bit n from icache n.
- iaddr0  in  ADDR_W  fetch address, core 0.
- iaddr1  in  ADDR_W  fetch address, core 1.
- iwait  out  2  bit n low = iload_n valid this cycle.
- iload0  out  DATA_W  fetched word, core 0.
- iload1  out  DATA_W  fetched word, core 1.
- dbus_req  in  1  data/coherence side wants the RAM port.
- ram_ren  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM read address.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ibus_busy  out  1  high while in FETCH; the bus controller must not drive the RAM.

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, last_grant=1 (core 0 preferred first), owner=0, addr_q=0.
  - Outputs: iwait=2'b11, iload0=iload1=0, ram_ren=0, ram_addr=0, ibus_busy=0.
- Reset mid-FETCH aborts the fetch immediately; no response is produced.
- Defaults in every cycle: iwait=2'b11, iload*=0, ram_ren=0, ram_addr=0.
- States: IDLE, FETCH.
- IDLE:
  - dbus_req=1 or iren=0: stay in IDLE.
  - Only one iren bit set: grant that core.
  - Both bits set: grant the core that is not last_grant.
  - On grant, register owner and addr_q=iaddr[owner], then go to FETCH. One cycle of arbitration latency.
- FETCH:
  - ram_ren=1, ram_addr=addr_q, ibus_busy=1.
  - ramstate==ACCESS: iwait[owner]=0 and iload[owner]=ramload combinationally in the same cycle; last_grant<=owner; next state IDLE.
  - ramstate FREE, BUSY or ERROR: hold in FETCH. ERROR is retried by holding ren.
  - iren[owner] drops, or iaddr[owner]!=addr_q: abort to IDLE. No iwait pulse; last_grant is unchanged.
  - dbus_req rising during FETCH does not preempt; the fetch completes first.
- Minimum latency: iren high at cycle t -> grant at edge t+1 -> iwait low in cycle t+1 if ramstate==ACCESS then.
- After every completion the arbiter passes through at least one IDLE cycle. There are no back-to-back fetches without re-arbitration.
- The non-owner core always sees iwait=1 and iload=0.
- Fairness: with both cores requesting continuously, grants alternate 0,1,0,1. No core waits more than one other fetch when dbus_req=0.

Test Plan:
- Reset, iren=2'b01, iaddr0=0x100, ramstate=ACCESS with ramload=0xDEADBEEF on the first FETCH cycle -> ram_addr=0x100, ram_ren=1 for 1 cycle, iwait=2'b10, iload0=0xDEADBEEF, then IDLE.
- iren=2'b11 held, iaddr0=0x10, iaddr1=0x20, ramstate ACCESS after 2 BUSY cycles each fetch -> serve order core0,core1,core0; ram_addr sequence 0x10,0x20,0x10; each iwait pulse is exactly 1 cycle.
- dbus_req=1 with iren=2'b01 -> ram_ren stays 0 and ibus_busy 0; dbus_req drops -> fetch is granted on the next edge.
- In FETCH for core 1 (ramstate BUSY), iren[1] drops -> return to IDLE, no iwait pulse; next iren=2'b11 still grants core 1 first (last_grant unchanged=0).
- ramstate=ERROR for 3 cycles then ACCESS -> ram_ren held high all 4 cycles with the same addr; single iwait pulse on the ACCESS cycle.
- nRST asserted mid-FETCH -> all outputs return to reset values asynchronously; after release, iren=2'b11 grants core 0 first.
